// File: rtl/mem_bist_ctrl.sv
// SRAM built-in self-test sequencer: word, halfword and byte write/read-back passes
// over words 0..DEPTH-1, sharing the SRAM port with the CPU through mem_req/mem_gnt.
module mem_bist_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              start,
  input  logic              mem_gnt,
  input  logic [31:0]       mem_rdata,
  output logic              mem_req,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       status,
  output logic [ADDR_W-1:0] fail_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_PH_START, S_WR, S_RD, S_CHK, S_PH_END, S_DONE
  } state_e;

  typedef enum logic [1:0] {PH_WORD, PH_HALF, PH_BYTE} phase_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [15:0]       status_q, status_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  phase_e      phase_next;
  logic [3:0]  x_nib, x_next, lane_mask;
  logic [15:0] idx16, v16;
  logic [7:0]  b8;
  logic [31:0] wr_data, exp_data;

  // Per-phase write pattern, lane mask and expected read-back.
  always_comb begin
    idx16      = 16'(idx_q);
    v16        = idx16 ^ 16'h0F0F;
    b8         = 8'(idx_q) ^ 8'h3C;
    x_nib      = 4'h4;
    x_next     = 4'h2;
    phase_next = PH_HALF;
    lane_mask  = 4'hF;
    wr_data    = {16'hA5A5, idx16};
    exp_data   = {16'hA5A5, idx16};
    case (phase_q)
      PH_HALF: begin
        x_nib      = 4'h2;
        x_next     = 4'h1;
        phase_next = PH_BYTE;
        lane_mask  = 4'b0011;
        wr_data    = {v16, v16};
        exp_data   = {16'hA5A5, v16};
      end
      PH_BYTE: begin
        x_nib      = 4'h1;
        x_next     = 4'h1;
        phase_next = PH_BYTE;
        lane_mask  = 4'b0100;
        wr_data    = {4{b8}};
        exp_data   = {8'hA5, b8, v16};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    fail_addr_d = fail_addr_q;
    status_d    = status_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_PH_START;
          phase_d     = PH_WORD;
          idx_d       = '0;
          status_d    = {8'hA0, 4'h4, 4'h0};
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
        end
      end
      S_PH_START: begin
        idx_d   = '0;
        state_d = S_WR;
      end
      S_WR: if (mem_gnt) state_d = S_RD;
      S_RD: if (mem_gnt) state_d = S_CHK;
      S_CHK: begin
        if (mem_rdata != exp_data) begin
          status_d    = {8'hAB, x_nib, 4'h0};
          fail_addr_d = idx_q;
          pass_d      = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_DONE;
        end else if (idx_q == LAST_ADDR) begin
          status_d = {8'hAB, x_nib, 4'h1};
          state_d  = S_PH_END;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_WR;
        end
      end
      S_PH_END: begin
        if (phase_q == PH_BYTE) begin
          done_d  = 1'b1;
          pass_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          phase_d  = phase_next;
          status_d = {8'hA0, x_next, 4'h0};
          state_d  = S_PH_START;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_WORD;
      idx_q       <= '0;
      fail_addr_q <= '0;
      status_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      fail_addr_q <= fail_addr_d;
      status_q    <= status_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  // Strobes follow mem_gnt combinationally so no access is ever issued without the grant.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_wdata = '0;
    if (state_q == S_WR) begin
      mem_wdata = wr_data;
      if (mem_gnt) begin
        mem_en = 1'b1;
        mem_we = lane_mask;
      end
    end else if (state_q == S_RD && mem_gnt) begin
      mem_en = 1'b1;
    end
  end

  assign mem_req   = busy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign status    = status_q;
  assign fail_addr = fail_addr_q;
  assign mem_addr  = idx_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: SRAM model with optional faults, plus a slot-schedule
// reference of the test sequence derived from the published timing and data rules.
module tb_mem_bist_ctrl;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned PH_CYC  = 2 + 3 * DEPTH;
  localparam int unsigned MAX_CYC = 20000;
  localparam int K_S = 0, K_W = 1, K_R = 2, K_C = 3, K_E = 4;
  localparam int OUT_W = 1 + 1 + 4 + ADDR_W + 32 + 1 + 1 + 1 + 16 + ADDR_W;

  logic              clock = 1'b0;
  logic              resetb = 1'b0;
  logic              start = 1'b0;
  logic              mem_gnt = 1'b0;
  logic [31:0]       mem_rdata;
  logic              mem_req, mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy, done, pass;
  logic [15:0]       status;
  logic [ADDR_W-1:0] fail_addr;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  typedef struct { int kind; int ph; int a; } slot_t;
  slot_t sched[$];

  mem_bist_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .resetb(resetb), .start(start), .mem_gnt(mem_gnt),
    .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .pass(pass), .status(status), .fail_addr(fail_addr)
  );

  always #5 clock = ~clock;

  // SRAM model: 1-cycle read latency, byte enables honoured unless full_write is set.
  logic [31:0] sram [DEPTH];
  logic [3:0]  last_we = 4'h0;
  bit          full_write = 1'b0;
  bit          stuck_en = 1'b0;
  int unsigned stuck_bit = 0;
  int unsigned rst_writes = 0;

  always @(posedge clock) begin
    if (mem_en && mem_we != 4'h0) begin
      last_we <= mem_we;
      if (!resetb) rst_writes <= rst_writes + 1;
      for (int k = 0; k < 4; k++)
        if (full_write || mem_we[k]) sram[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
    end else if (mem_en) begin
      mem_rdata <= sram[mem_addr] |
        ((stuck_en && last_we == 4'b0100 && mem_addr >= 7) ? (32'h1 << stuck_bit) : 32'h0);
    end
  end

  function automatic logic [31:0] f_read(int ph, int a);
    logic [15:0] v;
    logic [7:0]  b;
    v = 16'(a) ^ 16'h0F0F;
    b = 8'(a) ^ 8'h3C;
    if (ph == 0) return {16'hA5A5, 16'(a)};
    if (ph == 1) return {16'hA5A5, v};
    return {8'hA5, b, v};
  endfunction

  function automatic logic [31:0] f_wdata(int ph, int a);
    logic [15:0] v;
    logic [7:0]  b;
    v = 16'(a) ^ 16'h0F0F;
    b = 8'(a) ^ 8'h3C;
    if (ph == 0) return {16'hA5A5, 16'(a)};
    if (ph == 1) return {v, v};
    return {b, b, b, b};
  endfunction

  function automatic logic [3:0] f_we(int ph);
    if (ph == 0) return 4'hF;
    if (ph == 1) return 4'b0011;
    return 4'b0100;
  endfunction

  function automatic logic [15:0] f_code(int hi, int ph, int lo);
    return {8'(hi), 4'(4 >> ph), 4'(lo)};
  endfunction

  task automatic test_reset();
    logic [OUT_W-1:0] outs;
    resetb = 1'b0; start = 1'b0; mem_gnt = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    outs = {mem_req, mem_en, mem_we, mem_addr, mem_wdata, busy, done, pass, status, fail_addr};
    vectors++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    vectors++;
    if (status !== 16'h0000) begin
      errors++; $display("FAIL reset_status: got %h want 0000", status);
    end
    @(negedge clock);
    resetb = 1'b1;
  endtask

  task automatic test_pass_run(input bit rand_gnt, input bit extra_start, input string nm);
    int p, stalls, cyc;
    slot_t s;
    logic [15:0] es, m;
    logic [3:0] ewe;
    bit acc;
    p = 0; stalls = 0;
    @(negedge clock); start = 1'b1; mem_gnt = 1'b1;
    for (cyc = 1; cyc < MAX_CYC && p <= sched.size(); cyc++) begin
      @(negedge clock);
      start   = extra_start && cyc == 100;
      mem_gnt = rand_gnt ? 1'($urandom_range(1, 0)) : 1'b1;
      #1;
      if (p == sched.size()) begin
        vectors++;
        if ({done, pass, busy, mem_req} !== 4'b1100) begin
          errors++; $display("FAIL %s end_flags: got %b want 1100", nm, {done, pass, busy, mem_req});
        end
        vectors++;
        if (status !== 16'hAB11) begin
          errors++; $display("FAIL %s end_status: got %h want AB11", nm, status);
        end
        vectors++;
        if (cyc != 3 * PH_CYC + 1 + stalls) begin
          errors++; $display("FAIL %s done_cycle: got %0d want %0d", nm, cyc, 3 * PH_CYC + 1 + stalls);
        end
        p++;
      end else begin
        s   = sched[p];
        es  = (s.kind == K_E) ? f_code(8'hAB, s.ph, 1) : f_code(8'hA0, s.ph, 0);
        acc = (s.kind == K_W || s.kind == K_R) && mem_gnt;
        ewe = (acc && s.kind == K_W) ? f_we(s.ph) : 4'h0;
        vectors++;
        if ({busy, mem_req, done} !== 3'b110) begin
          errors++; $display("FAIL %s run_flags cyc=%0d: got %b want 110", nm, cyc, {busy, mem_req, done});
        end
        vectors++;
        if (status !== es) begin
          errors++; $display("FAIL %s status cyc=%0d: got %h want %h", nm, cyc, status, es);
        end
        vectors++;
        if (mem_en !== acc || mem_we !== ewe) begin
          errors++; $display("FAIL %s strobe cyc=%0d: got en=%b we=%h want en=%b we=%h",
                             nm, cyc, mem_en, mem_we, acc, ewe);
        end
        if (acc) begin
          vectors++;
          if (mem_addr !== ADDR_W'(s.a)) begin
            errors++; $display("FAIL %s addr cyc=%0d: got %h want %h", nm, cyc, mem_addr, ADDR_W'(s.a));
          end
          if (s.kind == K_W) begin
            vectors++;
            if (mem_wdata !== f_wdata(s.ph, s.a)) begin
              errors++; $display("FAIL %s wdata cyc=%0d: got %h want %h", nm, cyc, mem_wdata, f_wdata(s.ph, s.a));
            end
          end
        end
        if (!rand_gnt && (cyc == 770 || cyc == 771 || cyc == 1540 || cyc == 1541 || cyc == 2310)) begin
          case (cyc)
            770:     m = 16'hAB41;
            771:     m = 16'hA020;
            1540:    m = 16'hAB21;
            1541:    m = 16'hA010;
            default: m = 16'hAB11;
          endcase
          vectors++;
          if (status !== m) begin
            errors++; $display("FAIL %s milestone cyc=%0d: got %h want %h", nm, cyc, status, m);
          end
        end
        if ((s.kind == K_W || s.kind == K_R) && !mem_gnt) stalls++;
        else p++;
      end
    end
    vectors++;
    if (p <= sched.size()) begin
      errors++; $display("FAIL %s timeout: got slot %0d want %0d", nm, p, sched.size() + 1);
    end
  endtask

  task automatic test_final_memory();
    int a;
    vectors++;
    if (sram[5] !== 32'hA5390F0A) begin
      errors++; $display("FAIL final_word5: got %h want A5390F0A", sram[5]);
    end
    repeat (4) begin
      a = $urandom_range(DEPTH - 1, 0);
      vectors++;
      if (sram[a] !== f_read(2, a)) begin
        errors++; $display("FAIL final_word a=%0d: got %h want %h", a, sram[a], f_read(2, a));
      end
    end
  endtask

  task automatic test_no_byte_enables();
    int cyc, done_cyc;
    bit saw_a010;
    full_write = 1'b1; saw_a010 = 1'b0; done_cyc = -1;
    @(negedge clock); start = 1'b1; mem_gnt = 1'b1;
    for (cyc = 1; cyc < MAX_CYC && done_cyc < 0; cyc++) begin
      @(negedge clock); start = 1'b0; #1;
      if (status == 16'hA010) saw_a010 = 1'b1;
      if (done) done_cyc = cyc;
    end
    vectors++;
    if (done_cyc != int'(PH_CYC) + 5) begin
      errors++; $display("FAIL nobe_done_cycle: got %0d want %0d", done_cyc, PH_CYC + 5);
    end
    vectors++;
    if (status !== 16'hAB20 || fail_addr !== '0) begin
      errors++; $display("FAIL nobe_result: got %h/%h want AB20/00", status, fail_addr);
    end
    vectors++;
    if ({pass, busy, mem_req, saw_a010} !== 4'b0000) begin
      errors++; $display("FAIL nobe_flags: got %b want 0000", {pass, busy, mem_req, saw_a010});
    end
    full_write = 1'b0;
  endtask

  task automatic test_stuck_bit();
    int cyc, done_cyc;
    logic [31:0] e;
    e = f_read(2, 7);
    do stuck_bit = $urandom_range(31, 0); while (e[stuck_bit]);
    stuck_en = 1'b1; done_cyc = -1;
    @(negedge clock); start = 1'b1; mem_gnt = 1'b1;
    for (cyc = 1; cyc < MAX_CYC && done_cyc < 0; cyc++) begin
      @(negedge clock); start = 1'b0; #1;
      if (done) done_cyc = cyc;
    end
    vectors++;
    if (done_cyc != int'(2 * PH_CYC) + 5 + 3 * 7) begin
      errors++; $display("FAIL stuck_done_cycle bit=%0d: got %0d want %0d", stuck_bit, done_cyc, 2 * PH_CYC + 26);
    end
    vectors++;
    if (status !== 16'hAB10 || fail_addr !== ADDR_W'(7)) begin
      errors++; $display("FAIL stuck_result bit=%0d: got %h/%h want AB10/07", stuck_bit, status, fail_addr);
    end
    vectors++;
    if ({done, pass, mem_req} !== 3'b100) begin
      errors++; $display("FAIL stuck_flags: got %b want 100", {done, pass, mem_req});
    end
    stuck_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [OUT_W-1:0] outs;
    int n;
    n = $urandom_range(1530, 780);
    @(negedge clock); start = 1'b1; mem_gnt = 1'b1;
    repeat (n) begin @(negedge clock); start = 1'b0; end
    #2 resetb = 1'b0;
    #1;
    outs = {mem_req, mem_en, mem_we, mem_addr, mem_wdata, busy, done, pass, status, fail_addr};
    vectors++;
    if (outs !== '0) begin
      errors++; $display("FAIL midreset_outputs cyc=%0d: got %h want 0", n, outs);
    end
    repeat (3) @(negedge clock);
    #1;
    vectors++;
    if (rst_writes != 0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL midreset_writes: got %0d en=%b want 0 en=0", rst_writes, mem_en);
    end
    resetb = 1'b1;
  endtask

  initial begin
    for (int ph = 0; ph < 3; ph++) begin
      sched.push_back('{K_S, ph, 0});
      for (int a = 0; a < int'(DEPTH); a++) begin
        sched.push_back('{K_W, ph, a});
        sched.push_back('{K_R, ph, a});
        sched.push_back('{K_C, ph, a});
      end
      sched.push_back('{K_E, ph, 0});
    end
    test_reset();
    test_pass_run(1'b0, 1'b0, "nominal");
    test_final_memory();
    test_pass_run(1'b0, 1'b1, "restart_ignored");
    test_pass_run(1'b1, 1'b0, "gnt_random");
    test_no_byte_enables();
    test_stuck_bit();
    test_reset_mid();
    test_pass_run(1'b0, 1'b0, "after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
